// File: rtl/uart_decode_if.sv
// System-side bundle of the UART packet decoder: the serial line in, packet and status out.
interface uart_decode_if #(
    parameter int PACKET_WIDTH = 4
);
    logic                         uart_stream;
    logic [PACKET_WIDTH-1:0][7:0] sys_packet;
    logic                         done;
    logic                         parity_error;
    logic                         frame_error;
    logic                         busy;

    modport master (
        input  uart_stream,
        output sys_packet, done, parity_error, frame_error, busy
    );

    modport slave (
        output uart_stream,
        input  sys_packet, done, parity_error, frame_error, busy
    );
endinterface

// File: rtl/uart_decode.sv
// Oversampling UART receiver that reassembles PACKET_WIDTH even-parity bytes into one packet.
module uart_decode #(
    parameter int PACKET_WIDTH = 4,
    parameter int OVERSAMPLE   = 16,
    parameter int IDLE_TIMEOUT = 32
) (
    input logic           clk_baud,
    input logic           rst,
    uart_decode_if.master bus
);
    localparam int CW             = $clog2(OVERSAMPLE);
    localparam int IW             = $clog2(PACKET_WIDTH) + 1;
    localparam int TIMEOUT_CYCLES = IDLE_TIMEOUT * OVERSAMPLE;
    localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] MID_START    = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] MID_BIT      = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] LAST_INDEX   = IW'(PACKET_WIDTH - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic [1:0]                   sync_ff;
    logic [1:0]                   sync_valid;
    logic                         armed;
    logic                         rx;
    logic [2:0]                   state;
    logic [CW-1:0]                sample_cnt;
    logic [2:0]                   bit_cnt;
    logic [7:0]                   shift;
    logic                         parity_bad;
    logic [IW-1:0]                index;
    logic                         pkt_parity;
    logic [PACKET_WIDTH-1:0][7:0] staging;
    logic [TW-1:0]                idle_cnt;
    logic                         commit;
    logic                         commit_parity;
    logic [PACKET_WIDTH-1:0][7:0] packet_q;
    logic                         done_q;
    logic                         parity_error_q;
    logic                         frame_error_q;
    logic                         mid_bit;

    assign rx      = sync_ff[1];
    assign mid_bit = (sample_cnt == MID_BIT);

    // armed only sets once a genuine high has passed through both flops, so a line
    // that is low when reset releases cannot be mistaken for a start bit.
    always_ff @(posedge clk_baud or posedge rst) begin
        if (rst) begin
            sync_ff    <= 2'b11;
            sync_valid <= 2'b00;
            armed      <= 1'b0;
        end else begin
            sync_ff    <= {sync_ff[0], bus.uart_stream};
            sync_valid <= {sync_valid[0], 1'b1};
            if (sync_valid[1] && rx)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk_baud or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            sample_cnt    <= '0;
            bit_cnt       <= '0;
            shift         <= '0;
            parity_bad    <= 1'b0;
            index         <= '0;
            pkt_parity    <= 1'b0;
            staging       <= '0;
            idle_cnt      <= '0;
            commit        <= 1'b0;
            commit_parity <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            commit        <= 1'b0;
            frame_error_q <= 1'b0;
            sample_cnt    <= mid_bit ? '0 : sample_cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    if (armed && !rx) begin
                        state      <= S_START;
                        sample_cnt <= '0;
                        idle_cnt   <= '0;
                    end else if (index != '0) begin
                        if (idle_cnt == TIMEOUT_LAST) begin
                            index      <= '0;
                            pkt_parity <= 1'b0;
                            idle_cnt   <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end else begin
                        idle_cnt <= '0;
                    end
                end
                S_START: begin
                    if (sample_cnt == MID_START) begin
                        if (rx) begin
                            state <= S_IDLE;
                        end else begin
                            state      <= S_DATA;
                            sample_cnt <= '0;
                            bit_cnt    <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (mid_bit) begin
                        shift[bit_cnt] <= rx;
                        bit_cnt        <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= S_PARITY;
                    end
                end
                S_PARITY: begin
                    if (mid_bit) begin
                        parity_bad <= rx ^ (^shift);
                        state      <= S_STOP;
                    end
                end
                // Leaving at mid-stop gives half a bit of slack to catch a back-to-back start.
                S_STOP: begin
                    if (mid_bit) begin
                        if (rx) begin
                            state <= S_IDLE;
                            for (int i = 0; i < PACKET_WIDTH; i++) begin
                                if (index == IW'(i))
                                    staging[i] <= shift;
                            end
                            if (index == LAST_INDEX) begin
                                commit        <= 1'b1;
                                commit_parity <= pkt_parity | parity_bad;
                                index         <= '0;
                                pkt_parity    <= 1'b0;
                            end else begin
                                index      <= index + 1'b1;
                                pkt_parity <= pkt_parity | parity_bad;
                            end
                        end else begin
                            frame_error_q <= 1'b1;
                            index         <= '0;
                            pkt_parity    <= 1'b0;
                            state         <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    if (rx)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The staging buffer is published one cycle after the last byte lands, so the
    // consumer always sees a whole packet change at once.
    always_ff @(posedge clk_baud or posedge rst) begin
        if (rst) begin
            packet_q       <= '0;
            done_q         <= 1'b0;
            parity_error_q <= 1'b0;
        end else begin
            done_q <= commit;
            if (commit) begin
                packet_q       <= staging;
                parity_error_q <= commit_parity;
            end
        end
    end

    assign bus.sys_packet   = packet_q;
    assign bus.done         = done_q;
    assign bus.parity_error = parity_error_q;
    assign bus.frame_error  = frame_error_q;
    assign bus.busy         = (state != S_IDLE) || (index != '0);
endmodule

// File: tb/tb_uart_decode.sv
// Scoreboard bench for uart_decode: a frame-level model predicts packets, a monitor checks every done.
module tb_uart_decode;
    localparam int PW = 4;
    localparam int OS = 16;
    localparam int TO = 32;

    typedef struct packed {
        logic [PW-1:0][7:0] packet;
        logic               parity;
    } exp_t;

    logic clk_baud = 1'b0;
    logic rst      = 1'b1;

    uart_decode_if #(.PACKET_WIDTH(PW)) bus();

    uart_decode #(
        .PACKET_WIDTH(PW),
        .OVERSAMPLE  (OS),
        .IDLE_TIMEOUT(TO)
    ) dut (
        .clk_baud(clk_baud),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk_baud = ~clk_baud;

    exp_t               exp_q[$];
    logic [7:0]         model_bytes[$];
    logic               model_par = 1'b0;
    logic [PW-1:0][7:0] held = '0;
    int compared = 0;
    int mismatched = 0;
    int done_count = 0;
    int exp_frame_errors = 0;
    int seen_frame_errors = 0;
    int stability_violations = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: pops one expectation per done and watches that sys_packet never moves otherwise.
    always @(negedge clk_baud) begin
        exp_t e;
        if (rst) begin
            held = '0;
        end else if (bus.done) begin
            done_count++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                checkOutput("sys_packet", 64'(bus.sys_packet), 64'(e.packet));
                checkOutput("parity_error", 64'(bus.parity_error), 64'(e.parity));
                held = e.packet;
            end
        end else if (bus.sys_packet !== held) begin
            stability_violations++;
        end
        if (!rst && bus.frame_error)
            seen_frame_errors++;
    end

    task automatic sendBit(input logic v);
        bus.uart_stream = v;
        repeat (OS) @(negedge clk_baud);
    endtask

    task automatic modelClear();
        model_bytes.delete();
        model_par = 1'b0;
    endtask

    // Long idles discard the partial packet; gaps are only ever <=4 or >=TO bit-times.
    task automatic idleBits(input int n);
        if (n >= TO)
            modelClear();
        repeat (n) sendBit(1'b1);
    endtask

    // The model is updated before the frame goes out, since done fires mid-stop.
    task automatic applyStimulus(input logic [7:0] data, input logic bad_parity, input logic bad_stop);
        logic [PW-1:0][7:0] pkt;
        if (bad_stop) begin
            exp_frame_errors++;
            modelClear();
        end else begin
            model_bytes.push_back(data);
            model_par = model_par | bad_parity;
            if (model_bytes.size() == PW) begin
                for (int i = 0; i < PW; i++)
                    pkt[i] = model_bytes[i];
                exp_q.push_back('{packet: pkt, parity: model_par});
                modelClear();
            end
        end
        sendBit(1'b0);
        for (int i = 0; i < 8; i++)
            sendBit(data[i]);
        sendBit((^data) ^ bad_parity);
        if (bad_stop) begin
            repeat (3) sendBit(1'b0);
            sendBit(1'b1);
        end else begin
            sendBit(1'b1);
        end
    endtask

    initial begin
        int d0;
        int fe0;
        int r;
        bus.uart_stream = 1'b1;
        repeat (3) @(negedge clk_baud);
        checkOutput("reset_sys_packet", 64'(bus.sys_packet), 64'(0));
        checkOutput("reset_done", 64'(bus.done), 64'(0));
        checkOutput("reset_parity_error", 64'(bus.parity_error), 64'(0));
        checkOutput("reset_frame_error", 64'(bus.frame_error), 64'(0));
        checkOutput("reset_busy", 64'(bus.busy), 64'(0));
        rst = 1'b0;
        idleBits(2);

        $display("[TB] clean back-to-back packet");
        d0 = done_count;
        applyStimulus(8'h55, 1'b0, 1'b0);
        applyStimulus(8'hA3, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        applyStimulus(8'hFF, 1'b0, 1'b0);
        idleBits(2);
        checkOutput("clean_done_count", 64'(done_count - d0), 64'(1));

        $display("[TB] parity error packet then clean packet");
        applyStimulus(8'h55, 1'b0, 1'b0);
        applyStimulus(8'hA3, 1'b1, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        applyStimulus(8'hFF, 1'b0, 1'b0);
        idleBits(1);
        applyStimulus(8'h5A, 1'b0, 1'b0);
        applyStimulus(8'hC3, 1'b0, 1'b0);
        applyStimulus(8'h0F, 1'b0, 1'b0);
        applyStimulus(8'h81, 1'b0, 1'b0);
        idleBits(2);

        $display("[TB] bad stop bit then recovery");
        d0  = done_count;
        fe0 = seen_frame_errors;
        applyStimulus(8'h12, 1'b0, 1'b0);
        applyStimulus(8'h34, 1'b0, 1'b1);
        idleBits(1);
        applyStimulus(8'h11, 1'b0, 1'b0);
        applyStimulus(8'h22, 1'b0, 1'b0);
        applyStimulus(8'h33, 1'b0, 1'b0);
        applyStimulus(8'h44, 1'b0, 1'b0);
        idleBits(2);
        checkOutput("frame_error_pulses", 64'(seen_frame_errors - fe0), 64'(1));
        checkOutput("recovery_done_count", 64'(done_count - d0), 64'(1));

        $display("[TB] quarter-bit glitch");
        d0 = done_count;
        bus.uart_stream = 1'b0;
        repeat (OS / 4) @(negedge clk_baud);
        bus.uart_stream = 1'b1;
        repeat (2) @(negedge clk_baud);
        checkOutput("glitch_busy_high", 64'(bus.busy), 64'(1));
        idleBits(2);
        checkOutput("glitch_busy_low", 64'(bus.busy), 64'(0));
        checkOutput("glitch_done_count", 64'(done_count - d0), 64'(0));

        $display("[TB] idle timeout drops partial packet");
        d0 = done_count;
        applyStimulus(8'hAA, 1'b0, 1'b0);
        applyStimulus(8'hBB, 1'b0, 1'b0);
        idleBits(40);
        applyStimulus(8'h01, 1'b0, 1'b0);
        applyStimulus(8'h02, 1'b0, 1'b0);
        applyStimulus(8'h03, 1'b0, 1'b0);
        applyStimulus(8'h04, 1'b0, 1'b0);
        idleBits(2);
        checkOutput("timeout_done_count", 64'(done_count - d0), 64'(1));

        $display("[TB] reset in the middle of a frame");
        applyStimulus(8'h9C, 1'b1, 1'b0);
        applyStimulus(8'h01, 1'b0, 1'b0);
        applyStimulus(8'h02, 1'b0, 1'b0);
        applyStimulus(8'h03, 1'b0, 1'b0);
        idleBits(1);
        applyStimulus(8'h10, 1'b0, 1'b0);
        applyStimulus(8'h20, 1'b0, 1'b0);
        bus.uart_stream = 1'b0;
        repeat (3 * OS + OS / 2) @(negedge clk_baud);
        @(posedge clk_baud);
        #2 rst = 1'b1;
        modelClear();
        #1;
        checkOutput("midreset_sys_packet", 64'(bus.sys_packet), 64'(0));
        checkOutput("midreset_parity_error", 64'(bus.parity_error), 64'(0));
        checkOutput("midreset_done", 64'(bus.done), 64'(0));
        checkOutput("midreset_busy", 64'(bus.busy), 64'(0));
        @(posedge clk_baud);
        #2 rst = 1'b0;
        repeat (2 * OS) @(negedge clk_baud);
        checkOutput("low_line_after_reset_busy", 64'(bus.busy), 64'(0));
        idleBits(2);
        d0 = done_count;
        applyStimulus(8'hDE, 1'b0, 1'b0);
        applyStimulus(8'hAD, 1'b0, 1'b0);
        applyStimulus(8'hBE, 1'b0, 1'b0);
        applyStimulus(8'hEF, 1'b0, 1'b0);
        idleBits(2);
        checkOutput("post_reset_done_count", 64'(done_count - d0), 64'(1));

        $display("[TB] randomized frames");
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 99));
            applyStimulus(8'($urandom), ($urandom_range(0, 7) == 0), (r < 5));
            r = int'($urandom_range(0, 99));
            if (r < 5)
                idleBits(40);
            else
                idleBits(int'($urandom_range(0, 3)));
        end
        idleBits(3);

        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        checkOutput("frame_error_total", 64'(seen_frame_errors), 64'(exp_frame_errors));
        checkOutput("sys_packet_stability", 64'(stability_violations), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/uart_decode.md
Name: uart_decode

Overview:
- Receive-side counterpart of the UART packet encoder.
- Deserialises an 11-bit-per-byte UART stream and reassembles PACKET_WIDTH bytes into a parallel packet. Frame order is start(0), d0..d7 LSB first, even-parity bit (XOR of data), stop(1).
- Oversamples the line on clk_baud, which runs at OVERSAMPLE × bit rate.
- Pulses done with the packet and its error status to the system-side consumer.

Parameters:
- PACKET_WIDTH, 4, bytes per packet (≥1).
- OVERSAMPLE, 16, clk_baud cycles per bit (even, ≥4).
- IDLE_TIMEOUT, 32, idle bit-times after which a partial packet is discarded.

Ports:
- clk_baud  input  1  oversampling clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- uart_stream  input  1  serial line; idles high; asynchronous to clk_baud.
- sys_packet  output  [PACKET_WIDTH-1:0][7:0]  last completed packet; byte 0 is the first received.
- done  output  1  one-cycle pulse when sys_packet is updated.
- parity_error  output  1  valid with done: ≥1 byte of this packet failed parity.
- frame_error  output  1  one-cycle pulse on bad stop bit.
- busy  output  1  high while not in IDLE state or while byte index ≠ 0.

Behaviour:
- Reset (async assert, sync deassert in use):
  - sys_packet = 0; done = parity_error = frame_error = 0.
  - State = IDLE; byte index = 0; sample counter = 0; idle counter = 0.
  - Synchroniser flops = 1.
- Input synchronisation: uart_stream passes through 2 flops; all decisions use the synchronised value rx. Latency from line to rx is 2 cycles.
- States:
  - IDLE: wait for rx = 0. On detection, clear sample counter and go to START.
  - START: at count OVERSAMPLE/2-1 (mid-bit), re-check rx. If rx = 1, treat as a glitch and return to IDLE with no error. If rx = 0, clear the counter and go to DATA.
  - DATA: sample rx every OVERSAMPLE cycles (mid-bit) into shift register bit k, k = 0..7. After bit 7, go to PARITY.
  - PARITY: sample at mid-bit; parity_bad = sample XOR (^data). Go to STOP.
  - STOP: sample at mid-bit.
    - rx = 1: byte accepted; go to IDLE immediately (mid-stop), so back-to-back frames are caught.
    - rx = 0: frame_error pulses; discard the byte; byte index = 0; clear the packet-parity flag; go to BREAK.
  - BREAK: wait for rx = 1, then go to IDLE.
- Byte acceptance:
  - Store the byte into staging buffer[index].
  - OR parity_bad into the packet-parity flag.
  - A byte with bad parity is still stored.
- Packet completion:
  - In the cycle a byte is accepted with index = PACKET_WIDTH-1:
    - Copy the staging buffer, including that byte, to sys_packet atomically in the next cycle.
    - done = 1 for one cycle; parity_error = packet flag, held until the next done.
    - Index and flag clear to 0.
  - sys_packet never changes except on done.
- Idle timeout:
  - In IDLE with index ≠ 0, count cycles.
  - At IDLE_TIMEOUT × OVERSAMPLE, discard the partial packet (index = 0, flag = 0). No done and no error pulse.
  - The counter clears on any start detection.
- Width rules:
  - Sample counter is $clog2(OVERSAMPLE) bits and wraps.
  - Byte index is $clog2(PACKET_WIDTH)+1 bits.
  - Idle counter is sized for IDLE_TIMEOUT × OVERSAMPLE.
- Simultaneous events: a frame error and a timeout cannot coincide (they occur in different states). done and a new start detection may occur in the same cycle; both are honoured.
- Reset mid-frame: everything returns to reset values immediately. The remainder of the frame on the line is ignored until rx is high, because IDLE needs a falling level only after rx = 1 is seen once post-reset.
- Throughput: accepts continuous frames with stop bits of ≥0.5 bit-time length. Tolerates ±4% baud mismatch at OVERSAMPLE = 16.

Test Plan:
- PACKET_WIDTH=4, OVERSAMPLE=16, frames for bytes 0x55, 0xA3, 0x00, 0xFF back-to-back with correct parity -> exactly one done pulse ~2 cycles after the last mid-stop; sys_packet = {FF,00,A3,55}; parity_error = 0.
- Same stimulus, but the parity bit of 0xA3 is inverted -> done pulses; sys_packet = {FF,00,A3,55}; parity_error = 1. The next clean packet returns parity_error = 0.
- Stop bit of the second byte forced to 0, line held low 3 bit-times, then 4 clean bytes 0x11..0x44 -> one frame_error pulse, no done from the corrupted packet; then done with sys_packet = {44,33,22,11}.
- A 0.25-bit-time low glitch on an idle line -> no state change beyond START, no done, no error, busy returns to 0.
- 2 bytes sent, then line idle for 40 bit-times, then 4 bytes 0x01..0x04 -> partial packet dropped; single done with sys_packet = {04,03,02,01}.
- rst asserted mid-DATA of byte 3 for 1 cycle -> outputs go to 0 asynchronously; after rst, a full 4-byte packet decodes correctly.
